breath_ctrl: RTL and testbench

BREATH_CTRL -- requirements
Module: breath_ctrl

---
 rtl/breath_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_breath_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/breath_ctrl.sv
// breath_ctrl: LED "breathing" controller with PWM drive and colour cycling.
// Duty ramps 0 -> DUTY_MAX, holds, ramps back to 0, holds, then the colour
// index advances and the next breath starts while en_i stays high.
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_i        synchronous active-high reset
//   en_i         run enable, sampled in IDLE and at the HOLD_LO exit
//   duty_o       current brightness duty (0..DUTY_MAX)
//   pwm_o        registered PWM drive, (pwm_cnt < duty) over a 255 period
//   color_idx_o  colour index 0..5
//   color_adv_o  one-cycle pulse following each colour advance
//   phase_o      state code: IDLE=0 RAMP_UP=1 HOLD_HI=2 RAMP_DOWN=3 HOLD_LO=4
//   busy_o       high whenever the FSM is not in IDLE
module breath_ctrl #(
  parameter int unsigned STEP_CYC = 4,
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned DUTY_MAX = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [7:0] duty_o,
  output logic       pwm_o,
  output logic [2:0] color_idx_o,
  output logic       color_adv_o,
  output logic [2:0] phase_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    HOLD_HI = 3'd2,
    RAMP_DN = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam logic [15:0] STEP_LAST = 16'(STEP_CYC - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
  localparam logic [7:0]  DMAX      = 8'(DUTY_MAX);
  localparam logic [7:0]  PWM_LAST  = 8'd254;

  // The state register is plain logic so that codes 5..7 are
  // representable and can be recovered from.
  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [15:0] step_q;
  logic [15:0] step_d;
  logic [15:0] hold_q;
  logic [15:0] hold_d;
  logic [7:0]  duty_q;
  logic [7:0]  duty_d;
  logic [7:0]  pwm_cnt_q;
  logic [7:0]  pwm_cnt_d;
  logic        pwm_q;
  logic        pwm_d;
  logic [2:0]  color_q;
  logic [2:0]  color_d;
  logic        adv_q;
  logic        adv_d;

  logic        tick;
  logic        hold_done;
  logic        in_ramp;
  logic        in_hold;

  assign tick      = (step_q == STEP_LAST);
  assign hold_done = (hold_q == HOLD_LAST);
  assign in_ramp   = (state_q == RAMP_UP) ||
                     (state_q == RAMP_DN);
  assign in_hold   = (state_q == HOLD_HI) ||
                     (state_q == HOLD_LO);

  // Next state, duty and colour.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    color_d = color_q;
    adv_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = RAMP_UP;
          duty_d  = 8'd0;
        end
      end
      RAMP_UP: begin
        if (tick) begin
          // Saturate at DMAX; reaching it leaves the ramp.
          if (duty_q >= DMAX - 8'd1) begin
            duty_d  = DMAX;
            state_d = HOLD_HI;
          end else begin
            duty_d = duty_q + 8'd1;
          end
        end
      end
      HOLD_HI: begin
        if (hold_done) begin
          state_d = RAMP_DN;
        end
      end
      RAMP_DN: begin
        if (tick) begin
          // Floor at zero; reaching it leaves the ramp.
          if (duty_q <= 8'd1) begin
            duty_d  = 8'd0;
            state_d = HOLD_LO;
          end else begin
            duty_d = duty_q - 8'd1;
          end
        end
      end
      HOLD_LO: begin
        if (hold_done) begin
          color_d = (color_q == 3'd5) ? 3'd0
                                      : color_q + 3'd1;
          adv_d   = 1'b1;
          duty_d  = 8'd0;
          state_d = en_i ? RAMP_UP : IDLE;
        end
      end
      default: begin
        // Unused codes fall back to IDLE; duty is left alone
        // and is cleared on the next RAMP_UP entry.
        state_d = IDLE;
      end
    endcase
  end

  // Prescaler and hold counter restart on every state entry.
  always_comb begin
    step_d = 16'd0;
    hold_d = 16'd0;
    if (state_d == state_q) begin
      if (in_ramp) begin
        step_d = tick ? 16'd0 : step_q + 16'd1;
      end
      if (in_hold) begin
        hold_d = hold_q + 16'd1;
      end
    end
  end

  // Free-running PWM period and compare on pre-edge values.
  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? 8'd0
                                        : pwm_cnt_q + 8'd1;
    pwm_d     = (pwm_cnt_q < duty_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      step_q    <= 16'd0;
      hold_q    <= 16'd0;
      duty_q    <= 8'd0;
      pwm_cnt_q <= 8'd0;
      pwm_q     <= 1'b0;
      color_q   <= 3'd0;
      adv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      hold_q    <= hold_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
      color_q   <= color_d;
      adv_q     <= adv_d;
    end
  end

  assign duty_o      = duty_q;
  assign pwm_o       = pwm_q;
  assign color_idx_o = color_q;
  assign color_adv_o = adv_q;
  assign phase_o     = state_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_breath_ctrl.sv
// tb_breath_ctrl: scoreboard bench for breath_ctrl.
// Main instance uses STEP=2 HOLD=3 DUTY_MAX=4; a second checks PWM at 255.
module tb_breath_ctrl;

  localparam int S = 2;
  localparam int H = 3;
  localparam int D = 4;
  localparam int L = 2 * D * S + 2 * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       en_a  = 1'b0;
  logic       rst_b = 1'b1;
  logic       en_b  = 1'b0;
  logic [7:0] duty_a;
  logic [7:0] duty_b;
  logic       pwm_a;
  logic       pwm_b;
  logic [2:0] col_a;
  logic [2:0] col_b;
  logic       adv_a;
  logic       adv_b;
  logic [2:0] ph_a;
  logic [2:0] ph_b;
  logic       busy_a;
  logic       busy_b;

  breath_ctrl #(
    .STEP_CYC(S),
    .HOLD_CYC(H),
    .DUTY_MAX(D)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_a),
    .en_i       (en_a),
    .duty_o     (duty_a),
    .pwm_o      (pwm_a),
    .color_idx_o(col_a),
    .color_adv_o(adv_a),
    .phase_o    (ph_a),
    .busy_o     (busy_a)
  );

  breath_ctrl #(
    .STEP_CYC(1),
    .HOLD_CYC(600),
    .DUTY_MAX(255)
  ) dut_pwm (
    .clk_i      (clk),
    .rst_i      (rst_b),
    .en_i       (en_b),
    .duty_o     (duty_b),
    .pwm_o      (pwm_b),
    .color_idx_o(col_b),
    .color_adv_o(adv_b),
    .phase_o    (ph_b),
    .busy_o     (busy_b)
  );

  typedef struct packed {
    logic [7:0] duty;
    logic       pwm;
    logic [2:0] col;
    logic       adv;
    logic [2:0] ph;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  // Reference model: position t within the breath, counted
  // from the RAMP_UP entry edge.
  bit m_act;
  int m_t;
  int m_col;
  bit m_adv;
  int m_cnt;
  int m_duty;
  bit m_pwm;
  int m_ph;

  function automatic void model_edge(input bit r,
                                     input bit e);
    if (r) begin
      m_act  = 0;
      m_t    = 0;
      m_col  = 0;
      m_adv  = 0;
      m_cnt  = 0;
      m_duty = 0;
      m_pwm  = 0;
      m_ph   = 0;
    end else begin
      m_pwm = (m_cnt < m_duty);
      m_cnt = (m_cnt == 254) ? 0 : m_cnt + 1;
      m_adv = 0;
      if (!m_act) begin
        if (e) begin
          m_act = 1;
          m_t   = 0;
        end
      end else begin
        m_t++;
        if (m_t == L) begin
          m_col = (m_col + 1) % 6;
          m_adv = 1;
          m_t   = 0;
          m_act = e;
        end
      end
      m_ph   = 0;
      m_duty = 0;
      if (m_act) begin
        if (m_t < D * S) begin
          m_ph   = 1;
          m_duty = m_t / S;
        end else if (m_t < D * S + H) begin
          m_ph   = 2;
          m_duty = D;
        end else if (m_t < 2 * D * S + H) begin
          m_ph   = 3;
          m_duty = D - (m_t - D * S - H) / S;
        end else begin
          m_ph   = 4;
          m_duty = 0;
        end
      end
    end
  endfunction

  function automatic exp_t cur_exp();
    exp_t x;
    x.duty = 8'(m_duty);
    x.pwm  = m_pwm;
    x.col  = 3'(m_col);
    x.adv  = m_adv;
    x.ph   = 3'(m_ph);
    x.busy = (m_ph != 0);
    return x;
  endfunction

  // Drive one edge on the main instance and queue its result.
  task automatic tick(input bit r, input bit e);
    @(negedge clk);
    rst_a = r;
    en_a  = e;
    model_edge(r, e);
    sb_q.push_back(cur_exp());
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t ex;
    #1;
    if (sb_q.size() != 0) begin
      ex = sb_q.pop_front();
      check("sb", 32'({duty_a, pwm_a, col_a,
                       adv_a, ph_a, busy_a}),
            32'(ex));
    end
  end

  int col_seq[6] = '{1, 2, 3, 4, 5, 0};
  int pulses;
  int ones;
  int n;

  initial begin
    // Reset state and basic breath.
    tick(1, 0);
    tick(1, 0);
    check("rst_outs",
          32'({duty_a, pwm_a, col_a,
               adv_a, ph_a, busy_a}), 32'd0);
    for (int e = 0; e <= 22; e++) begin
      tick(0, 1);
      if (e == 2 || e == 4 || e == 6 || e == 8)
        check($sformatf("up_duty_e%0d", e),
              32'(duty_a), 32'(e / 2));
      if (e == 8)
        check("hh_phase", 32'(ph_a), 32'd2);
      if (e == 11)
        check("rd_phase", 32'(ph_a), 32'd3);
      if (e >= 13 && e <= 19 && (e % 2) == 1)
        check($sformatf("dn_duty_e%0d", e),
              32'(duty_a), 32'((19 - e) / 2));
      check($sformatf("adv_e%0d", e),
            32'(adv_a), 32'(e == 22));
      if (e == 22) begin
        check("b_col", 32'(col_a), 32'd1);
        check("b_phase", 32'(ph_a), 32'd1);
      end
    end

    // Six breaths: colour wraps back to 0.
    tick(1, 0);
    pulses = 0;
    for (int k = 0; k <= 6 * L; k++) begin
      tick(0, 1);
      if (adv_a) begin
        pulses++;
        if (pulses <= 6)
          check($sformatf("wrap_col%0d", pulses),
                32'(col_a), 32'(col_seq[pulses - 1]));
      end
    end
    check("wrap_pulses", 32'(pulses), 32'd6);

    // Graceful stop: en dropped at edge 5.
    tick(1, 0);
    for (int e = 0; e <= 25; e++) begin
      tick(0, e < 5);
      if (e == 22) begin
        check("gs_col", 32'(col_a), 32'd1);
        check("gs_phase", 32'(ph_a), 32'd0);
        check("gs_busy", 32'(busy_a), 32'd0);
      end
    end

    // Reset mid-ramp at edge 6.
    tick(1, 0);
    for (int e = 0; e <= 5; e++) tick(0, 1);
    tick(1, 1);
    check("mr_duty", 32'(duty_a), 32'd0);
    check("mr_phase", 32'(ph_a), 32'd0);
    check("mr_pwm", 32'(pwm_a), 32'd0);
    check("mr_col", 32'(col_a), 32'd0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick(0, 0);
      pulses += int'(adv_a);
    end
    check("mr_no_adv", 32'(pulses), 32'd0);

    // Reset on the HOLD_LO exit edge: no colour advance.
    tick(1, 0);
    for (int e = 0; e <= 21; e++) tick(0, 1);
    tick(1, 1);
    check("rx_col", 32'(col_a), 32'd0);
    tick(0, 0);
    check("rx_adv", 32'(adv_a), 32'd0);

    // Illegal state code recovers to IDLE, duty kept.
    tick(1, 0);
    for (int e = 0; e <= 4; e++) tick(0, 1);
    check("il_pre", 32'(duty_a), 32'd2);
    @(negedge clk);
    en_a = 1'b0;
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    check("il_forced", 32'(ph_a), 32'd6);
    @(posedge clk);
    #2;
    check("il_phase", 32'(ph_a), 32'd0);
    check("il_duty", 32'(duty_a), 32'd2);
    @(negedge clk);
    @(posedge clk);
    #2;
    check("il_duty2", 32'(duty_a), 32'd2);
    @(negedge clk);
    en_a = 1'b1;
    @(posedge clk);
    #2;
    check("il_reup", 32'(ph_a), 32'd1);
    check("il_clr", 32'(duty_a), 32'd0);

    // PWM at full duty during HOLD_HI, and idle.
    rst_b = 1'b1;
    tick(1, 0);
    tick(1, 0);
    rst_b = 1'b0;
    en_b  = 1'b1;
    n = 0;
    while (ph_b != 3'd2 && n < 2000) begin
      tick(1, 0);
      n++;
    end
    check("pw_hold", 32'(ph_b), 32'd2);
    tick(1, 0);
    tick(1, 0);
    check("pw_peak", 32'(duty_b), 32'd255);
    ones = 0;
    for (int i = 0; i < 255; i++) begin
      tick(1, 0);
      ones += int'(pwm_b);
    end
    check("pw_hi_ones", 32'(ones), 32'd255);
    check("pw_still_hh", 32'(ph_b), 32'd2);
    rst_b = 1'b1;
    tick(1, 0);
    rst_b = 1'b0;
    en_b  = 1'b0;
    ones = 0;
    for (int i = 0; i < 255; i++) begin
      tick(1, 0);
      ones += int'(pwm_b);
    end
    check("pw_idle_ones", 32'(ones), 32'd0);
    check("pw_idle_ph", 32'(ph_b), 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
